// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and line levels.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  localparam int unsigned UART_DATA_W    = 8;
  localparam logic        UART_IDLE_LVL  = 1'b1;
  localparam logic        UART_START_LVL = 1'b0;

  function automatic logic uart_even_parity(input logic [UART_DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake between the producer (master) and the UART transmitter (slave).
interface uart_tx_ctrl_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] tx_data;
  logic                   tx_valid;
  logic                   tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_bit_cnt.sv
// 3-bit data bit index counter with synchronous clear; done flags the last data bit.
module uart_bit_cnt (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       clr,
  output logic [2:0] count,
  output logic       done
);

  always_ff @(posedge clk) begin
    if (!rst_n)   count <= '0;
    else if (clr) count <= '0;
    else if (ena) count <= count + 3'd1;
  end

  assign done = (count == 3'd7);

endmodule

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmit sequencer: start, 8 data bits LSB-first, optional even parity, stop.
// Define UART_TX_PARITY_EN to insert the parity bit between data and stop.
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter  int unsigned CLKS_PER_BIT = 16,
  localparam int unsigned BAUD_W       = $clog2(CLKS_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  uart_tx_ctrl_if.slave        tx_if,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  uart_state_t            state;
  logic [BAUD_W-1:0]      baud;
  logic [UART_DATA_W-1:0] shreg;
  logic                   baud_end;
  logic                   accept;
  logic                   bit_done;
  logic [2:0]             bit_idx;
  logic                   unused_bit_idx;
`ifdef UART_TX_PARITY_EN
  logic                   parity;
`endif

  assign baud_end       = (baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign tx_if.tx_ready = ena && (state == IDLE);
  assign accept         = tx_if.tx_valid && tx_if.tx_ready;
  // Decoded from held state so a pulse falling in an ena=0 window is deferred, not lost.
  assign tx_done        = ena && (state == STOP) && baud_end;
  assign unused_bit_idx = ^bit_idx;

  uart_bit_cnt u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena && (state == DATA) && baud_end),
    .clr   (accept),
    .count (bit_idx),
    .done  (bit_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      baud   <= '0;
      shreg  <= '0;
      tx     <= UART_IDLE_LVL;
      busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else if (ena) begin
      if (state != IDLE) baud <= baud_end ? '0 : baud + 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg  <= tx_if.tx_data;
            state  <= START;
            tx     <= UART_START_LVL;
            busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity <= uart_even_parity(tx_if.tx_data);
`endif
          end
        end
        START: begin
          if (baud_end) begin
            state <= DATA;
            tx    <= shreg[0];
          end
        end
        DATA: begin
          if (baud_end) begin
            shreg <= shreg >> 1;
            if (bit_done) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity;
`else
              state <= STOP;
              tx    <= UART_IDLE_LVL;
`endif
            end else begin
              tx <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            state <= STOP;
            tx    <= UART_IDLE_LVL;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= UART_IDLE_LVL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl against a frame-level bit-list reference model.
module tb_uart_tx_ctrl;
  import uart_pkg::*;

  localparam int C = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic ena   = 1'b1;
  logic tx, busy, tx_done;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  uart_tx_ctrl_if bus_if ();

  uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .tx_if   (bus_if.slave),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Entered at a negedge with the DUT idle and ena=1; leaves at the idle negedge after the frame.
  // p is the frame position in enabled cycles; each frame bit spans C positions.
  task automatic frame(input logic [7:0] b, input int gap_at, input int gap_len,
                       input bit hold, input int rst_at);
    logic exp_bits[NB];
    int   p, gap_left, ndone, limit;
    bit   e_prev, gap_used;
    exp_bits[0] = UART_START_LVL;
    for (int i = 0; i < 8; i++) exp_bits[1+i] = b[i];
`ifdef UART_TX_PARITY_EN
    exp_bits[9] = ^b;
`endif
    exp_bits[NB-1] = UART_IDLE_LVL;
    check("ready_before_accept", bus_if.tx_ready, 1);
    bus_if.tx_valid = 1'b1;
    bus_if.tx_data  = b;
    p = -1; e_prev = 1'b1; gap_left = 0; gap_used = 1'b0; ndone = 0;
    limit = NB*C + gap_len + 4;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (e_prev) p++;
      if (p == NB*C) begin
        check("idle_tx", tx, 1);
        check("idle_busy", busy, 0);
        check("idle_done", tx_done, 0);
        check("idle_ready", bus_if.tx_ready, 1);
        check("done_count", ndone, 1);
        return;
      end
      check("tx_bit", tx, exp_bits[p/C]);
      check("busy", busy, 1);
      check("tx_done", tx_done, ena && (p == NB*C-1));
      check("ready_busy", bus_if.tx_ready, 0);
      if (tx_done === 1'b1) ndone++;
      if (p == rst_at) begin
        rst_n = 1'b0;
        bus_if.tx_valid = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_done", tx_done, 0);
        check("rst_no_done", ndone, 0);
        rst_n = 1'b1;
        return;
      end
      if (!gap_used && p == gap_at && gap_len > 0) begin
        gap_used = 1'b1;
        gap_left = gap_len;
      end
      if (gap_left > 0) begin
        ena = 1'b0;
        gap_left--;
      end else begin
        ena = 1'b1;
      end
      e_prev = ena;
      bus_if.tx_data  = 8'($urandom);
      bus_if.tx_valid = hold ? 1'b1 : ((p >= NB*C-1) ? 1'b0 : 1'($urandom_range(0, 1)));
    end
    check("frame_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    bus_if.tx_valid = 1'b0;
    bus_if.tx_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_tx", tx, 1);
    check("reset_busy", busy, 0);
    check("reset_done", tx_done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle20_tx", tx, 1);
      check("idle20_ready", bus_if.tx_ready, 1);
      check("idle20_busy", busy, 0);
    end

    frame(8'hA5, -1, 0, 1'b0, -1);

    t0 = cyc;
    frame(8'h00, -1, 0, 1'b1, -1);
    check("b2b_period", cyc - t0, NB*C + 1);
    frame(8'hFF, -1, 0, 1'b0, -1);

    frame(8'h3C, -1, 0, 1'b0, 4*C + 1);
    frame(8'h81, -1, 0, 1'b0, -1);

    frame(8'hC3, 1, 7, 1'b0, -1);
    frame(8'h07, -1, 0, 1'b0, -1);
    frame(8'h6E, NB*C - 1, 3, 1'b0, -1);

    ena = 1'b0;
    bus_if.tx_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ena_off_ready", bus_if.tx_ready, 0);
      check("ena_off_busy", busy, 0);
      check("ena_off_tx", tx, 1);
    end
    ena = 1'b1;
    bus_if.tx_valid = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 1) == 1)
        frame(8'($urandom), int'($urandom_range(0, NB*C - 1)), int'($urandom_range(1, 6)), 1'b0, -1);
      else
        frame(8'($urandom), -1, 0, 1'b0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
